// File: rtl/data_bus.sv
// Central shared datapath bus: selects one source by read_en, zero-extends it
// to bus_width bits and registers it onto busout (one-cycle latency).
module data_bus #(
  parameter int bus_width = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           read_en,
  input  logic [7:0]           dm,
  input  logic [15:0]          im,
  input  logic [15:0]          pc,
  input  logic [15:0]          ir,
  input  logic [15:0]          ar,
  input  logic [23:0]          ac,
  input  logic [7:0]           x,
  input  logic [7:0]           y,
  input  logic [7:0]           z,
  input  logic [15:0]          stxy,
  input  logic [15:0]          styz,
  input  logic [15:0]          stxz,
  input  logic [15:0]          r,
  input  logic [7:0]           r1,
  input  logic [23:0]          r2,
  input  logic [15:0]          r3,
  input  logic [15:0]          dr,
  output logic [bus_width-1:0] busout
);

  logic [bus_width-1:0] w_sel;
  logic [bus_width-1:0] r_busout;

  // Upper bits stay at the '0 default, giving zero-extension for narrow sources.
  // Codes 0 and 18-31, and any unknown code, fall through to a zero bus.
  always_comb begin
    w_sel = '0;
    case (read_en)
      5'd1:    w_sel[7:0]  = dm;
      5'd2:    w_sel[15:0] = im;
      5'd3:    w_sel[15:0] = pc;
      5'd4:    w_sel[15:0] = ir;
      5'd5:    w_sel[15:0] = ar;
      5'd6:    w_sel[23:0] = ac;
      5'd7:    w_sel[7:0]  = x;
      5'd8:    w_sel[7:0]  = y;
      5'd9:    w_sel[7:0]  = z;
      5'd10:   w_sel[15:0] = stxy;
      5'd11:   w_sel[15:0] = styz;
      5'd12:   w_sel[15:0] = stxz;
      5'd13:   w_sel[15:0] = r;
      5'd14:   w_sel[7:0]  = r1;
      5'd15:   w_sel[23:0] = r2;
      5'd16:   w_sel[15:0] = r3;
      5'd17:   w_sel[15:0] = dr;
      default: w_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busout <= '0;
    else        r_busout <= w_sel;
  end

  assign busout = r_busout;

endmodule

// File: tb/tb_data_bus.sv
// Bench for data_bus: directed steps followed by randomized back-to-back
// selections, checked against a table-driven reference model.
module tb_data_bus;

  logic        clk;
  logic        rst_n;
  logic [4:0]  read_en;
  logic [23:0] busout;
  logic [23:0] src [0:31];
  logic [23:0] exp_val;
  int          n_cmp;
  int          n_err;

  // Source width for each select code; 0 marks "no source".
  int src_w [0:31] = '{0, 8, 16, 16, 16, 16, 24, 8, 8, 8, 16, 16, 16, 16, 8, 24, 16, 16,
                       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  data_bus #(.bus_width(24)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en),
    .dm(src[1][7:0]), .im(src[2][15:0]), .pc(src[3][15:0]), .ir(src[4][15:0]),
    .ar(src[5][15:0]), .ac(src[6]), .x(src[7][7:0]), .y(src[8][7:0]), .z(src[9][7:0]),
    .stxy(src[10][15:0]), .styz(src[11][15:0]), .stxz(src[12][15:0]), .r(src[13][15:0]),
    .r1(src[14][7:0]), .r2(src[15]), .r3(src[16][15:0]), .dr(src[17][15:0]),
    .busout(busout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] model(input logic [4:0] code);
    logic [31:0] mask;
    if (src_w[code] == 0) return 24'h0;
    mask = (32'd1 << src_w[code]) - 32'd1;
    return src[code] & mask[23:0];
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 32; i++) src[i] = 24'h0;
  endtask

  task automatic randomize_sources(input bit nonzero);
    for (int i = 0; i < 32; i++) src[i] = 24'($urandom) | (nonzero ? 24'h000001 : 24'h0);
  endtask

  // Present a code at the falling edge, check it one rising edge later.
  task automatic apply(input string tag, input logic [4:0] code);
    @(negedge clk);
    read_en = code;
    exp_val = model(code);
    @(posedge clk);
    #1;
    check(tag, busout, exp_val);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_sources();
    read_en = 5'd3;
    src[3] = 24'h000010;

    // Reset holds the bus at zero across clock edges.
    repeat (3) @(posedge clk);
    #1 check("reset_hold", busout, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release_pc", busout, 24'h000010);

    // Walk codes 3..7 carrying the value 16.
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk);
      clear_sources();
      src[c] = 24'h000010;
      read_en = 5'(c);
      @(posedge clk);
      #1 check($sformatf("walk_code%0d", c), busout, 24'h000010);
    end

    // Zero-extension.
    clear_sources();
    src[1] = 24'h0000FF;
    apply("zext_dm", 5'd1);
    check("zext_dm_const", busout, 24'h0000FF);
    src[15] = 24'hABCDEF;
    apply("zext_r2", 5'd15);
    src[16] = 24'h008001;
    apply("zext_r3", 5'd16);
    check("zext_r3_const", busout, 24'h008001);

    // Isolation with every source busy.
    randomize_sources(1'b1);
    src[8] = 24'h00005A;
    src[9] = 24'h0000A5;
    src[12] = 24'h001234;
    apply("iso_stxz", 5'd12);
    check("iso_stxz_const", busout, 24'h001234);
    src[17] = 24'h00BEEF;
    apply("iso_dr", 5'd17);
    check("iso_dr_const", busout, 24'h00BEEF);

    // Null and reserved codes.
    randomize_sources(1'b1);
    apply("null_code0", 5'd0);
    apply("reserved_18", 5'd18);
    apply("reserved_31", 5'd31);
    check("reserved_31_const", busout, 24'h0);

    // Asynchronous reset mid-stream.
    src[15] = 24'hABCDEF;
    apply("pre_async_r2", 5'd15);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("async_drop", busout, 24'h0);
    @(posedge clk);
    #1 check("async_hold_edge", busout, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("async_no_stale", busout, 24'h0);
    @(posedge clk);
    #1 check("async_reload", busout, 24'hABCDEF);

    // Randomized back-to-back switching of codes and sources.
    for (int i = 0; i < 300; i++) begin
      randomize_sources(1'b0);
      apply("rand", 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
